alu_issue_pipe: RTL and testbench

//  - Two-stage valid/ready wrapper around the 8-bit combinational ALU (logic ops, shifts/rotates, mux16 select).
//  - Upstream: accepts {a, b, op} requests. Drives operands and a 4-bit select to the ALU. Registers alu_y plus flags.
//  - Downstream: presents the registered result. Throughput 1 op/cycle; tolerates downstream backpressure.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_issue_stage.sv | 36 +++
 rtl/alu_issue_pipe.sv | 131 +++++++++++++
 tb/tb_alu_issue_pipe.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU wrapper types: opcode enum, flag bundle and the flag generation helper.
// Used by alu_issue_pipe; optional accumulator forwarding is enabled with ALU_ACC_FWD_EN.
package alu_pkg;

    localparam int W = 8;

    typedef enum logic [3:0] {
        OP_NOT_A = 4'd0,
        OP_NOT_B = 4'd1,
        OP_OR    = 4'd2,
        OP_AND   = 4'd3,
        OP_XOR   = 4'd4,
        OP_ADD   = 4'd5,
        OP_SUB   = 4'd6,
        OP_LSL   = 4'd7,
        OP_LSR   = 4'd8,
        OP_ASR   = 4'd9,
        OP_ROL   = 4'd10,
        OP_ROR   = 4'd11
    } alu_op_t;

    localparam logic [3:0] OP_RESERVED_MIN = 4'd12;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic err;
    } flags_t;

    // Carry is only meaningful for the adder ops; the ALU drives its adder carry for every op.
    function automatic flags_t gen_flags(input logic [W-1:0] y, input logic cout, input logic [3:0] op);
        flags_t f;
        f.z   = (y == {W{1'b0}});
        f.n   = y[W-1];
        f.c   = ((op == OP_ADD) || (op == OP_SUB)) ? cout : 1'b0;
        f.err = (op >= OP_RESERVED_MIN);
        return f;
    endfunction

endpackage

// File: rtl/alu_issue_stage.sv
// Generic valid/ready register slice: a single payload register that can accept
// a new item in the same cycle its current item is taken downstream.
module alu_issue_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_r;
    logic [DW-1:0] data_r;

    assign in_ready  = !valid_r || out_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Slice register: load on accept, otherwise empty once the consumer advances
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            data_r  <= {DW{1'b0}};
        end else if (in_valid && in_ready) begin
            valid_r <= 1'b1;
            data_r  <= in_data;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_pipe.sv
// Two-stage valid/ready issue wrapper around an external 8-bit combinational ALU.
// Define ALU_ACC_FWD_EN to build the accumulator that can replace operand A.
module alu_issue_pipe #(
    parameter int W     = alu_pkg::W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [3:0]       in_op,
    input  logic             in_acc,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [3:0]       alu_sel,
    input  logic [W-1:0]     alu_y,
    input  logic             alu_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_y,
    output logic             out_z,
    output logic             out_n,
    output logic             out_c,
    output logic             out_err,
    output logic [CNT_W-1:0] ops_done
);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   op;
        logic         acc;
    } s1_t;

    localparam int S1_W = $bits(s1_t);

    s1_t              s1_in_s;
    s1_t              s1_q_s;
    logic             s1_valid_s;
    logic             adv1_s;
    logic             adv2_s;
    logic             s2_hs_s;
    logic             s2_valid_r;
    logic [W-1:0]     y_r;
    alu_pkg::flags_t  flags_r;
    logic [CNT_W-1:0] ops_done_r;

    assign s1_in_s = {in_a, in_b, in_op, in_acc};
    assign adv2_s  = !s2_valid_r || out_ready;
    assign adv1_s  = s1_valid_s && adv2_s;
    assign s2_hs_s = s2_valid_r && out_ready;

    alu_issue_stage #(
        .DW(S1_W)
    ) u_s1 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (s1_in_s),
        .out_valid(s1_valid_s),
        .out_ready(adv2_s),
        .out_data (s1_q_s)
    );

    assign alu_b   = s1_q_s.b;
    assign alu_sel = s1_q_s.op;

`ifdef ALU_ACC_FWD_EN
    logic [W-1:0] acc_r;

    // Accumulator captures every result leaving S1, i.e. the op just ahead of S1
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= {W{1'b0}};
        end else if (adv1_s) begin
            acc_r <= alu_y;
        end
    end

    // Operand A source: forwarded accumulator or the stored operand
    always_comb begin
        alu_a = s1_q_s.a;
        if (s1_q_s.acc) begin
            alu_a = acc_r;
        end else begin
            alu_a = s1_q_s.a;
        end
    end
`else
    logic acc_unused_s;

    assign acc_unused_s = s1_q_s.acc;
    assign alu_a        = s1_q_s.a;
`endif

    // Result slice: capture the ALU output and its flags as S1 advances
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_r <= 1'b0;
            y_r        <= {W{1'b0}};
            flags_r    <= alu_pkg::flags_t'(4'b0000);
        end else if (adv1_s) begin
            s2_valid_r <= 1'b1;
            y_r        <= alu_y;
            flags_r    <= alu_pkg::gen_flags(alu_y, alu_cout, s1_q_s.op);
        end else if (adv2_s) begin
            s2_valid_r <= 1'b0;
        end
    end

    // Completed-operation counter; assigned every cycle and wraps at full scale
    always_ff @(posedge clk) begin
        if (reset) begin
            ops_done_r <= {CNT_W{1'b0}};
        end else begin
            ops_done_r <= ops_done_r + {{(CNT_W-1){1'b0}}, s2_hs_s};
        end
    end

    assign out_valid = s2_valid_r;
    assign out_y     = y_r;
    assign out_z     = flags_r.z;
    assign out_n     = flags_r.n;
    assign out_c     = flags_r.c;
    assign out_err   = flags_r.err;
    assign ops_done  = ops_done_r;

endmodule

// File: tb/tb_alu_issue_pipe.sv
// Scoreboard bench for alu_issue_pipe with a stand-in ALU between the alu_* ports.
// Compile with ALU_ACC_FWD_EN defined to exercise accumulator forwarding.
module tb_alu_issue_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [3:0]  in_op;
    logic        in_acc;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_sel;
    logic [7:0]  alu_y;
    logic        alu_cout;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_y;
    logic        out_z;
    logic        out_n;
    logic        out_c;
    logic        out_err;
    logic [15:0] ops_done;

`ifdef ALU_ACC_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] y;
        logic       z;
        logic       n;
        logic       c;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_acc;
    int         checks;
    int         passes;
    int         hs_count;
    int         rdy_mode;

    always #5 clk = ~clk;

    alu_issue_pipe #(.W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_y(alu_y), .alu_cout(alu_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_z(out_z), .out_n(out_n), .out_c(out_c), .out_err(out_err),
        .ops_done(ops_done)
    );

    // Stand-in ALU: mux16 of bit ops and shifters; the adder carry is driven for every select
    function automatic logic [8:0] standin_alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        logic [8:0]  sum;
        logic [15:0] dbl;
        logic [7:0]  y;
        logic [2:0]  s;
        s   = b[2:0];
        dbl = {a, a};
        sum = (sel == 4'd6) ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b});
        case (sel)
            4'd0:       y = ~a;
            4'd1:       y = ~b;
            4'd2:       y = a | b;
            4'd3:       y = a & b;
            4'd4:       y = a ^ b;
            4'd5, 4'd6: y = sum[7:0];
            4'd7:       y = a << s;
            4'd8:       y = a >> s;
            4'd9:       y = $unsigned($signed(a) >>> s);
            4'd10:      begin dbl = dbl << s; y = dbl[15:8]; end
            4'd11:      begin dbl = dbl >> s; y = dbl[7:0]; end
            default:    y = a;
        endcase
        return {sum[8], y};
    endfunction

    assign {alu_cout, alu_y} = standin_alu(alu_a, alu_b, alu_sel);

    function automatic exp_t mk(input logic [7:0] y, input logic z, input logic n, input logic c, input logic err);
        exp_t e;
        e.y = y; e.z = z; e.n = n; e.c = c; e.err = err;
        return e;
    endfunction

    // Reference: integer arithmetic straight from the opcode definitions
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input logic acc);
        int ia, ib, s, r, p;
        bit c;
        exp_t e;
        ia = (FWD && acc) ? int'(model_acc) : int'(a);
        ib = int'(b);
        s  = ib % 8;
        p  = 1 << s;
        c  = 1'b0;
        case (op)
            4'd0:  r = 255 - ia;
            4'd1:  r = 255 - ib;
            4'd2:  r = ia | ib;
            4'd3:  r = ia & ib;
            4'd4:  r = ia ^ ib;
            4'd5:  begin r = ia + ib; c = (r > 255); r = r % 256; end
            4'd6:  begin c = (ia >= ib); r = (ia - ib + 256) % 256; end
            4'd7:  r = (ia * p) % 256;
            4'd8:  r = ia / p;
            4'd9:  r = ((ia >= 128 ? ia - 256 : ia) >>> s) & 255;
            4'd10: r = ((ia * p) % 256) | (ia / (256 / p));
            4'd11: r = (ia / p) | ((ia * (256 / p)) % 256);
            default: r = ia;
        endcase
        e.y   = 8'(r);
        e.z   = (r == 0);
        e.n   = (r >= 128);
        e.c   = c;
        e.err = (op >= 4'd12);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: chooses out_ready, pops and compares on every output handshake, checks hold stability
    initial begin
        logic        hold_v;
        logic [12:0] hold_val;
        exp_t        e;
        hold_v    = 1'b0;
        hold_val  = 13'd0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    check("hold_stable", {out_valid, out_y, out_z, out_n, out_c, out_err}, hold_val);
                end
                case (rdy_mode)
                    0:       out_ready = ($urandom_range(0, 3) != 0);
                    1:       out_ready = 1'b1;
                    default: out_ready = 1'b0;
                endcase
                if (out_valid && out_ready) begin
                    hold_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("spurious_out", {31'd0, out_valid}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {out_y, out_z, out_n, out_c, out_err}, e);
                        hs_count++;
                    end
                end else if (out_valid) begin
                    hold_v   = 1'b1;
                    hold_val = {out_valid, out_y, out_z, out_n, out_c, out_err};
                end else begin
                    hold_v = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input logic acc, input exp_t e);
        int n = 0;
        @(negedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_acc = acc;
        while (!in_ready && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("send_accept", {31'd0, in_ready}, 32'd1);
        if (in_ready) begin
            exp_q.push_back(e);
            model_acc = e.y;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        @(negedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
        @(negedge clk); #1;
    endtask

    initial begin
        logic [7:0] bp_a [4];
        logic [7:0] bp_b [4];
        logic [3:0] bp_op [4];
        logic [7:0] ra, rb;
        logic [3:0] rop;
        logic       racc;
        exp_t       e;
        int         k;
        checks = 0; passes = 0; hs_count = 0; rdy_mode = 1; model_acc = 8'h00;
        reset = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_op = 4'h0; in_acc = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_y", {24'd0, out_y}, 32'd0);
        check("rst_flags", {28'd0, out_z, out_n, out_c, out_err}, 32'd0);
        check("rst_ops_done", {16'd0, ops_done}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD with carry and exact two-cycle latency
        send(8'hF0, 8'h20, 4'd5, 1'b0, mk(8'h10, 1'b0, 1'b0, 1'b1, 1'b0));
        idle();
        check("lat_cycle1", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_cycle2", {31'd0, out_valid}, 32'd1);
        send(8'h5A, 8'h5A, 4'd4, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        send(8'h80, 8'h03, 4'd9, 1'b0, mk(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0));
        send(8'h3C, 8'hC8, 4'hD, 1'b0, mk(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1));
        send(8'h03, 8'h04, 4'd5, 1'b0, mk(8'h07, 1'b0, 1'b0, 1'b0, 1'b0));
        send(8'h01, 8'h01, 4'd7, 1'b1, mk(FWD ? 8'h0E : 8'h02, 1'b0, 1'b0, 1'b0, 1'b0));
        idle();
        drain();

        // Reset with two ops in flight
        rdy_mode = 2;
        @(negedge clk);
        send(8'h11, 8'h22, 4'd2, 1'b0, model(8'h11, 8'h22, 4'd2, 1'b0));
        send(8'h33, 8'h44, 4'd3, 1'b0, model(8'h33, 8'h44, 4'd3, 1'b0));
        @(negedge clk); #1;
        in_valid = 1'b0; reset = 1'b1; exp_q.delete();
        @(posedge clk); #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_ops_done", {16'd0, ops_done}, 32'd0);
        @(negedge clk); #1;
        reset = 1'b0; model_acc = 8'h00; hs_count = 0;

        // Backpressure: four back-to-back ops against a stalled output
        bp_a = '{8'h11, 8'h05, 8'h81, 8'h81};
        bp_b = '{8'h22, 8'h09, 8'h01, 8'h01};
        bp_op = '{4'd5, 4'd6, 4'd10, 4'd11};
        k = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk); #1;
            in_valid = 1'b1; in_a = bp_a[k]; in_b = bp_b[k]; in_op = bp_op[k]; in_acc = 1'b0;
            if (in_ready) begin
                e = model(bp_a[k], bp_b[k], bp_op[k], 1'b0);
                exp_q.push_back(e);
                model_acc = e.y;
                k++;
            end
            @(posedge clk);
        end
        check("bp_accepts", k, 32'd2);
        @(negedge clk); #1;
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        rdy_mode = 1;
        while (k < 4) begin
            send(bp_a[k], bp_b[k], bp_op[k], 1'b0, model(bp_a[k], bp_b[k], bp_op[k], 1'b0));
            k++;
        end
        idle();
        drain();
        check("bp_ops_done", {16'd0, ops_done}, 32'd4);

        // Randomized traffic with random backpressure
        rdy_mode = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                rop = 4'($urandom_range(0, 15));
                racc = 1'($urandom_range(0, 1));
                send(ra, rb, rop, racc, model(ra, rb, rop, racc));
            end
        end
        idle();
        rdy_mode = 1;
        drain();
        check("rand_ops_done", {16'd0, ops_done}, hs_count & 32'h0000FFFF);

        // Counter wrap from full scale
        force dut.ops_done_r = 16'hFFFF;
        @(posedge clk);
        @(negedge clk); #1;
        check("wrap_preload", {16'd0, ops_done}, 32'h0000FFFF);
        release dut.ops_done_r;
        @(posedge clk);
        send(8'h0F, 8'hF0, 4'd2, 1'b0, model(8'h0F, 8'hF0, 4'd2, 1'b0));
        idle();
        drain();
        check("wrap_ops_done", {16'd0, ops_done}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
